// File: rtl/idli_sqi_mem_m.sv
// SQI serial SRAM responder (sequential mode), byte storage with auto-increment.
// Optional RDMR (0x05) mode-register read: define IDLI_SQI_MEM_RDMR_EN.
module idli_sqi_mem_m #(
  parameter int MEM_BYTES = 1024
) (
  input  logic       i_mem_gck,
  input  logic       i_mem_rst_n,
  input  logic       i_mem_cs,
  input  logic [3:0] i_mem_data,
  output logic [3:0] o_mem_data,
  output logic       o_mem_oe
);

  localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    INSTR,
    ADDR,
    DUMMY,
    RDATA,
    WDATA,
    IGNORE
`ifdef IDLI_SQI_MEM_RDMR_EN
    , RDMR
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] addr_q;
  logic [1:0]  cnt_q;
  logic [3:0]  instr_hi_q;
  logic [3:0]  wr_hi_q;
  logic        wr_q;
  logic        oe_d;
  logic [3:0]  data_d;

  logic [7:0]  mem [MEM_BYTES];
  logic [7:0]  instr;
  logic [7:0]  rd_byte;
  logic        is_rd;
  logic        is_wr;
  logic        wr_en;

  assign instr   = {instr_hi_q, i_mem_data};
  assign is_rd   = (instr == 8'h03);
  assign is_wr   = (instr == 8'h02);
  assign rd_byte = mem[addr_q[AW-1:0]];
  assign wr_en   = !i_mem_cs && (state_q == WDATA) && cnt_q[0];

`ifdef IDLI_SQI_MEM_RDMR_EN
  logic is_rdmr;
  assign is_rdmr = (instr == 8'h05);
`endif

  always_ff @(posedge i_mem_gck) begin
    if (!i_mem_rst_n) state_q <= IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  state_d = INSTR;
      INSTR: begin
        unique case (1'b1)
          is_rd, is_wr: state_d = ADDR;
`ifdef IDLI_SQI_MEM_RDMR_EN
          is_rdmr:      state_d = RDMR;
`endif
          default:      state_d = IGNORE;
        endcase
      end
      ADDR:  if (cnt_q == 2'd3) state_d = wr_q ? WDATA : DUMMY;
      DUMMY: if (cnt_q[0]) state_d = RDATA;
      default: ;
    endcase
    // Deselect ends any transfer, whatever state we are in
    if (i_mem_cs) state_d = IDLE;
  end

  always_comb begin
    oe_d   = 1'b0;
    data_d = 4'h0;
    unique case (state_q)
      DUMMY: begin
        if (cnt_q[0]) begin
          oe_d   = 1'b1;
          data_d = rd_byte[7:4];
        end
      end
      RDATA: begin
        oe_d   = 1'b1;
        data_d = cnt_q[0] ? rd_byte[7:4] : rd_byte[3:0];
      end
`ifdef IDLI_SQI_MEM_RDMR_EN
      INSTR: begin
        if (is_rdmr) begin
          oe_d   = 1'b1;
          data_d = 4'h4;
        end
      end
      RDMR: begin
        oe_d   = 1'b1;
        data_d = cnt_q[0] ? 4'h4 : 4'h0;
      end
`endif
      default: ;
    endcase
    if (i_mem_cs) begin
      oe_d   = 1'b0;
      data_d = 4'h0;
    end
  end

  always_ff @(posedge i_mem_gck) begin
    if (!i_mem_rst_n) begin
      addr_q     <= '0;
      cnt_q      <= '0;
      instr_hi_q <= '0;
      wr_hi_q    <= '0;
      wr_q       <= 1'b0;
      o_mem_oe   <= 1'b0;
      o_mem_data <= '0;
    end else begin
      o_mem_oe   <= oe_d;
      o_mem_data <= data_d;
      cnt_q      <= (state_d != state_q) ? 2'd0 : cnt_q + 2'd1;
      unique case (state_q)
        IDLE:  instr_hi_q <= i_mem_data;
        INSTR: wr_q <= is_wr;
        ADDR:  addr_q <= {addr_q[11:0], i_mem_data};
        RDATA: if (!cnt_q[0]) addr_q <= addr_q + 16'd1;
        WDATA: begin
          if (!cnt_q[0]) wr_hi_q <= i_mem_data;
          else           addr_q  <= addr_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Storage is intentionally left uninitialised on reset
  always_ff @(posedge i_mem_gck) begin
    if (i_mem_rst_n && wr_en) mem[addr_q[AW-1:0]] <= {wr_hi_q, i_mem_data};
  end

endmodule

// File: tb/tb_idli_sqi_mem_m.sv
// Bench for idli_sqi_mem_m: vector table, directed corners, and
// randomized transactions against a byte-array memory model.
module tb_idli_sqi_mem_m;

  localparam int M = 1024;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs = 1'b1;
  logic [3:0] din = 4'h0;
  logic [3:0] dout;
  logic       oe;

  int tests = 0;
  int fails = 0;

  logic [7:0] ref_mem [M];

  typedef struct {
    logic       rst_n;
    logic       cs;
    logic [3:0] d;
    logic       oe;
    logic [3:0] q;
  } vec_t;

  vec_t tbl[$];

  idli_sqi_mem_m #(.MEM_BYTES(M)) dut (
    .i_mem_gck   (clk),
    .i_mem_rst_n (rst_n),
    .i_mem_cs    (cs),
    .i_mem_data  (din),
    .o_mem_data  (dout),
    .o_mem_oe    (oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic c, input logic [3:0] d);
    @(negedge clk);
    cs  = c;
    din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic step_quiet(input logic c, input logic [3:0] d,
                            input string nm);
    step(c, d);
    chk(nm, {27'd0, oe, dout}, 32'd0);
  endtask

  function automatic int idx(input logic [15:0] a, input int b);
    logic [15:0] s;
    s = a + 16'(b);
    return int'(s) % M;
  endfunction

  function automatic vec_t mk(input logic r, input logic c,
                              input logic [3:0] d, input logic o,
                              input logic [3:0] q);
    vec_t v;
    v.rst_n = r; v.cs = c; v.d = d; v.oe = o; v.q = q;
    return v;
  endfunction

  task automatic do_write(input logic [15:0] a, input logic [7:0] q[$],
                          input bit half);
    step_quiet(1'b0, 4'h0, "wr_instr");
    step_quiet(1'b0, 4'h2, "wr_instr");
    for (int i = 0; i < 4; i++)
      step_quiet(1'b0, a[15-4*i -: 4], "wr_addr");
    for (int i = 0; i < q.size(); i++) begin
      logic [7:0] b;
      b = q[i];
      step_quiet(1'b0, b[7:4], "wr_data");
      step_quiet(1'b0, b[3:0], "wr_data");
      ref_mem[idx(a, i)] = b;
    end
    if (half) step_quiet(1'b0, 4'($urandom), "wr_half");
    step_quiet(1'b1, 4'h0, "wr_end");
  endtask

  task automatic do_read(input logic [15:0] a, input int n);
    logic [3:0] nib [8];
    nib[0] = 4'h0; nib[1] = 4'h3;
    nib[2] = a[15:12]; nib[3] = a[11:8];
    nib[4] = a[7:4];   nib[5] = a[3:0];
    nib[6] = 4'($urandom); nib[7] = 4'($urandom);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, nib[i]);
      if (i < 7) chk("rd_pre", {27'd0, oe, dout}, 32'd0);
    end
    for (int k = 0; k < 2 * n; k++) begin
      logic [7:0] b;
      logic [3:0] e;
      if (k > 0) step(1'b0, 4'($urandom));
      b = ref_mem[idx(a, k / 2)];
      e = (k % 2 == 0) ? b[7:4] : b[3:0];
      chk("rd_data", {27'd0, oe, dout}, {27'd0, 1'b1, e});
    end
    step_quiet(1'b1, 4'h0, "rd_end");
  endtask

  task automatic do_ignore(input logic [7:0] ins);
    logic [7:0] v;
    v = ins;
    step_quiet(1'b0, v[7:4], "ign_instr");
    step_quiet(1'b0, v[3:0], "ign_instr");
    for (int i = 0; i < 10; i++)
      step_quiet(1'b0, 4'($urandom), "ign_body");
    step_quiet(1'b1, 4'h0, "ign_end");
  endtask

  initial begin
    logic [7:0] q[$];
    logic [3:0] seq_w [10];
    logic [3:0] seq_r [7];

    // Reset and the basic write/read transactions as a vector table
    for (int i = 0; i < 2; i++) tbl.push_back(mk(0, 1, 4'h0, 0, 4'h0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 1, 4'h0, 0, 4'h0));
    seq_w = '{4'h0, 4'h2, 4'h0, 4'h0, 4'h1, 4'h0,
              4'hA, 4'hB, 4'hC, 4'hD};
    foreach (seq_w[i]) tbl.push_back(mk(1, 0, seq_w[i], 0, 4'h0));
    tbl.push_back(mk(1, 1, 4'h0, 0, 4'h0));
    seq_r = '{4'h0, 4'h3, 4'h0, 4'h0, 4'h1, 4'h0, 4'h7};
    foreach (seq_r[i]) tbl.push_back(mk(1, 0, seq_r[i], 0, 4'h0));
    tbl.push_back(mk(1, 0, 4'h1, 1, 4'hA));
    tbl.push_back(mk(1, 0, 4'h2, 1, 4'hB));
    tbl.push_back(mk(1, 0, 4'h3, 1, 4'hC));
    tbl.push_back(mk(1, 0, 4'h4, 1, 4'hD));
    tbl.push_back(mk(1, 1, 4'h0, 0, 4'h0));
    tbl.push_back(mk(1, 1, 4'h0, 0, 4'h0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst_n = tbl[i].rst_n;
      cs    = tbl[i].cs;
      din   = tbl[i].d;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), {27'd0, oe, dout},
          {27'd0, tbl[i].oe, tbl[i].q});
    end
    ref_mem[16] = 8'hAB;
    ref_mem[17] = 8'hCD;

    // Give every byte a known value
    q.delete();
    for (int i = 0; i < M; i++) q.push_back(8'($urandom));
    do_write(16'h0000, q, 1'b0);
    do_read(16'h0000, 4);

    // Last array byte, then wrap to index 0
    q.delete(); q.push_back(8'h5A);
    do_write(16'h03FF, q, 1'b0);
    do_read(16'h03FF, 2);
    chk("edge_byte", {24'd0, ref_mem[M-1]}, 32'h5A);

    // Top of the 16-bit address space wraps to 0x0000
    do_read(16'hFFFF, 3);
    q.delete(); q.push_back(8'h11); q.push_back(8'h22);
    do_write(16'hFFFF, q, 1'b0);
    do_read(16'h0000, 1);
    do_read(16'h03FF, 1);

    // Deselect in the middle of a byte drops it
    q.delete(); q.push_back(8'h3C);
    do_write(16'h0100, q, 1'b1);
    do_read(16'h0100, 2);
    q.delete();
    do_write(16'h0200, q, 1'b1);
    do_read(16'h0200, 1);

    // Unknown instructions never drive the bus
    do_ignore(8'h9C);
    do_ignore(8'h13);
    do_ignore(8'h01);
`ifdef IDLI_SQI_MEM_RDMR_EN
    step_quiet(1'b0, 4'h0, "rdmr_instr");
    for (int i = 0; i < 6; i++) begin
      step(1'b0, (i == 0) ? 4'h5 : 4'($urandom));
      chk("rdmr_data", {27'd0, oe, dout},
          {27'd0, 1'b1, (i % 2 == 0) ? 4'h4 : 4'h0});
    end
    step_quiet(1'b1, 4'h0, "rdmr_end");
`else
    do_ignore(8'h05);
`endif

    // Reset during a read releases the bus
    for (int i = 0; i < 8; i++) step(1'b0, (i == 1) ? 4'h3 : 4'h0);
    chk("rst_pre", {31'd0, oe}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid", {27'd0, oe, dout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step_quiet(1'b1, 4'h0, "rst_idle");
    do_read(16'h0010, 2);

    // Random traffic against the model
    for (int t = 0; t < 40; t++) begin
      logic [15:0] a;
      int n;
      a = 16'($urandom);
      n = $urandom_range(1, 6);
      if ($urandom_range(0, 1) == 1) begin
        q.delete();
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        do_write(a, q, $urandom_range(0, 3) == 0);
      end else begin
        do_read(a, n);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
